// File: rtl/pll_reset_sequencer_if.sv
// Bundle of the PLL-side and downstream-side signals of pll_reset_sequencer.
// master = the sequencer, slave = the PLL / reset consumers / status reader.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_RESETS = 3,
    parameter int unsigned CNT_W      = 8
);
    logic                  pll_locked;
    logic                  pll_rst;
    logic [NUM_RESETS-1:0] rst_out_n;
    logic                  ready;
    logic [2:0]            state;
    logic [CNT_W-1:0]      lock_loss_cnt;
    logic [CNT_W-1:0]      retry_cnt;

    modport master (
        input  pll_locked,
        output pll_rst,
        output rst_out_n,
        output ready,
        output state,
        output lock_loss_cnt,
        output retry_cnt
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  rst_out_n,
        input  ready,
        input  state,
        input  lock_loss_cnt,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the synchronized lock, then
// releases staggered downstream resets. Lock-timeout retry enabled by PLL_RESET_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned NUM_RESETS          = 3,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned CNT_W               = 8
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned STG_W = $clog2(STAGGER_CYCLES + 1);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
`endif

    if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
        NUM_RESETS < 1 || STAGGER_CYCLES < 1 || CNT_W < 1) begin : g_param_check
        $error("pll_reset_sequencer: all cycle/count parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  locked_s;
    logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]      stb_cnt_q, stb_cnt_d;
    logic [STG_W-1:0]      stg_cnt_q, stg_cnt_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_RESETS-1:0] rst_out_n_q, rst_out_n_d;
    logic                  ready_q, ready_d;
    logic [CNT_W-1:0]      lock_loss_q, lock_loss_d;
    logic [NUM_RESETS-1:0] rst_out_n_shift_c;
    logic                  timeout_c;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]      retry_q, retry_d;
`endif

    assign locked_s = sync_q[1];

    // Released bits form a thermometer code; releasing the next one shifts in a 1.
    assign rst_out_n_shift_c = NUM_RESETS'({rst_out_n_q, 1'b1});

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    assign timeout_c = (to_cnt_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        pll_rst_d   = pll_rst_q;
        rst_out_n_d = rst_out_n_q;
        ready_d     = ready_q;
        lock_loss_d = lock_loss_q;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        retry_d     = retry_q;
`endif

        unique case (state_q)
            S_RESET_PLL: begin
                pll_rst_d = 1'b1;
                if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
                    state_d   = S_WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    rst_cnt_d = '0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end

            S_WAIT_LOCK: begin
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                if (timeout_c) begin
                    state_d   = S_RESET_PLL;
                    pll_rst_d = 1'b1;
                    rst_cnt_d = '0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                    if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
`endif
                end else if (locked_s) begin
                    state_d   = S_STABLE;
                    stb_cnt_d = '0;
                end
            end

            S_STABLE: begin
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                // Final stability count beats a coincident timeout; a timeout beats a lock drop.
                if (locked_s && stb_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                    rst_out_n_d = rst_out_n_shift_c;
                    stg_cnt_d   = '0;
                    if (&rst_out_n_shift_c) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else if (timeout_c) begin
                    state_d   = S_RESET_PLL;
                    pll_rst_d = 1'b1;
                    rst_cnt_d = '0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
                    if (retry_q != '1) retry_d = retry_q + CNT_W'(1);
`endif
                end else if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end

            S_RELEASE: begin
                if (!locked_s) begin
                    state_d     = S_RESET_PLL;
                    pll_rst_d   = 1'b1;
                    rst_cnt_d   = '0;
                    rst_out_n_d = '0;
                    ready_d     = 1'b0;
                    if (lock_loss_q != '1) lock_loss_d = lock_loss_q + CNT_W'(1);
                end else if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
                    rst_out_n_d = rst_out_n_shift_c;
                    stg_cnt_d   = '0;
                    if (&rst_out_n_shift_c) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end

            S_RUN: begin
                if (!locked_s) begin
                    state_d     = S_RESET_PLL;
                    pll_rst_d   = 1'b1;
                    rst_cnt_d   = '0;
                    rst_out_n_d = '0;
                    ready_d     = 1'b0;
                    if (lock_loss_q != '1) lock_loss_d = lock_loss_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = S_RESET_PLL;
                pll_rst_d   = 1'b1;
                rst_cnt_d   = '0;
                rst_out_n_d = '0;
                ready_d     = 1'b0;
            end
        endcase
    end

    // State, synchronizer, counters and output registers
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            sync_q      <= '0;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            stg_cnt_q   <= '0;
            pll_rst_q   <= 1'b1;
            rst_out_n_q <= '0;
            ready_q     <= 1'b0;
            lock_loss_q <= '0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], bus.pll_locked};
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
            lock_loss_q <= lock_loss_d;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
`endif
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.rst_out_n     = rst_out_n_q;
    assign bus.ready         = ready_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = lock_loss_q;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    assign bus.retry_cnt     = retry_q;
`else
    assign bus.retry_cnt     = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: vector table with a scoreboard queue,
// plus a hand-written lock-timeout pulse measurement.
module tb_pll_reset_sequencer;

    logic refclk = 1'b0;
    logic rst_n;

    always #10 refclk = ~refclk;

    pll_reset_sequencer_if #(.NUM_RESETS(3), .CNT_W(2)) bus ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(100),
        .NUM_RESETS         (3),
        .STAGGER_CYCLES     (2),
        .CNT_W              (2)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string    name;
        bit       rst_n;
        bit       locked;
        int       cycles;
        bit [2:0] st;
        bit       prst;
        bit [2:0] ron;
        bit       rdy;
        bit [1:0] llc;
        bit [1:0] rtc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   exp_iq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(string name, bit r, bit l, int c, bit [2:0] st, bit prst,
                                bit [2:0] ron, bit rdy, bit [1:0] llc, bit [1:0] rtc);
        vec_t v;
        v.name = name; v.rst_n = r; v.locked = l; v.cycles = c;
        v.st = st; v.prst = prst; v.ron = ron; v.rdy = rdy; v.llc = llc; v.rtc = rtc;
        vecs.push_back(v);
    endfunction

    task automatic check_int(string name, int got, int want);
        n_total++;
        if (got != want) $display("FAIL %s: got %0d, want %0d", name, got, want);
        else n_pass++;
    endtask

    task automatic count_while(input logic level, input int budget, output int n);
        n = 0;
        while (bus.pll_rst === level && n < budget) begin
            n++;
            @(negedge refclk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vec_t     e;
        bit [11:0] got, want;
        int       n;
        int       pulses, low_exp, rtc_exp;

        // Clean bring-up with lock already present
        add("rst_hold",        0, 1, 3, 3'd0, 1, 3'b000, 0, 2'd0, 2'd0);
        add("pll_rst_c2_4",    1, 1, 3, 3'd0, 1, 3'b000, 0, 2'd0, 2'd0);
        add("wait_lock",       1, 1, 1, 3'd1, 0, 3'b000, 0, 2'd0, 2'd0);
        add("stable_enter",    1, 1, 1, 3'd2, 0, 3'b000, 0, 2'd0, 2'd0);
        add("stable_hold",     1, 1, 7, 3'd2, 0, 3'b000, 0, 2'd0, 2'd0);
        add("release_b0",      1, 1, 1, 3'd3, 0, 3'b001, 0, 2'd0, 2'd0);
        add("release_b0_hold", 1, 1, 1, 3'd3, 0, 3'b001, 0, 2'd0, 2'd0);
        add("release_b1",      1, 1, 1, 3'd3, 0, 3'b011, 0, 2'd0, 2'd0);
        add("release_b1_hold", 1, 1, 1, 3'd3, 0, 3'b011, 0, 2'd0, 2'd0);
        add("run_ready",       1, 1, 1, 3'd4, 0, 3'b111, 1, 2'd0, 2'd0);
        add("run_hold",        1, 1, 5, 3'd4, 0, 3'b111, 1, 2'd0, 2'd0);
        // Lock loss in RUN, then a one-cycle glitch during requalification
        add("loss_sync",       1, 0, 2, 3'd4, 0, 3'b111, 1, 2'd0, 2'd0);
        add("loss_edge3",      1, 0, 1, 3'd0, 1, 3'b000, 0, 2'd1, 2'd0);
        add("loss_pll_rst",    1, 1, 3, 3'd0, 1, 3'b000, 0, 2'd1, 2'd0);
        add("loss_wait",       1, 1, 1, 3'd1, 0, 3'b000, 0, 2'd1, 2'd0);
        add("loss_stable",     1, 1, 1, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("glitch_pre",      1, 1, 5, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("glitch_lo",       1, 0, 1, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("glitch_hi",       1, 1, 1, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("glitch_wait",     1, 1, 1, 3'd1, 0, 3'b000, 0, 2'd1, 2'd0);
        add("requal_enter",    1, 1, 1, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("requal_hold",     1, 1, 7, 3'd2, 0, 3'b000, 0, 2'd1, 2'd0);
        add("requal_release",  1, 1, 1, 3'd3, 0, 3'b001, 0, 2'd1, 2'd0);
        add("requal_run",      1, 1, 4, 3'd4, 0, 3'b111, 1, 2'd1, 2'd0);
        // Repeated lock losses drive the 2-bit counter into saturation
        for (int k = 2; k <= 5; k++) begin
            bit [1:0] prev, cur;
            prev = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            cur  = (k > 3) ? 2'd3 : 2'(k);
            add($sformatf("sat%0d_sync", k),    1, 0, 2, 3'd4, 0, 3'b111, 1, prev, 2'd0);
            add($sformatf("sat%0d_loss", k),    1, 0, 1, 3'd0, 1, 3'b000, 0, cur,  2'd0);
            add($sformatf("sat%0d_pllrst", k),  1, 1, 3, 3'd0, 1, 3'b000, 0, cur,  2'd0);
            add($sformatf("sat%0d_wait", k),    1, 1, 1, 3'd1, 0, 3'b000, 0, cur,  2'd0);
            add($sformatf("sat%0d_stable", k),  1, 1, 1, 3'd2, 0, 3'b000, 0, cur,  2'd0);
            add($sformatf("sat%0d_release", k), 1, 1, 8, 3'd3, 0, 3'b001, 0, cur,  2'd0);
            if (k < 5)
                add($sformatf("sat%0d_run", k), 1, 1, 4, 3'd4, 0, 3'b111, 1, cur,  2'd0);
        end
        // rst_n asserted while in RELEASE
        add("rst_in_release",  0, 1, 1, 3'd0, 1, 3'b000, 0, 2'd0, 2'd0);

        rst_n          = 1'b0;
        bus.pll_locked = 1'b1;
        @(negedge refclk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n          = vecs[i].rst_n;
            bus.pll_locked = vecs[i].locked;
            exp_q.push_back(vecs[i]);
            repeat (vecs[i].cycles) @(negedge refclk);
            e    = exp_q.pop_front();
            got  = {bus.state, bus.pll_rst, bus.rst_out_n, bus.ready, bus.lock_loss_cnt, bus.retry_cnt};
            want = {e.st, e.prst, e.ron, e.rdy, e.llc, e.rtc};
            n_total++;
            if (got !== want)
                $display("FAIL %s: got st=%0d pll_rst=%b rst_out_n=%b ready=%b lock_loss=%0d retry=%0d, want st=%0d pll_rst=%b rst_out_n=%b ready=%b lock_loss=%0d retry=%0d",
                         e.name, bus.state, bus.pll_rst, bus.rst_out_n, bus.ready,
                         bus.lock_loss_cnt, bus.retry_cnt,
                         e.st, e.prst, e.ron, e.rdy, e.llc, e.rtc);
            else
                n_pass++;
        end

        // Lock never arrives: measure pll_rst pulse width and spacing
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
        pulses  = 4;
        low_exp = 100;
`else
        pulses  = 1;
        low_exp = 150;
`endif
        rst_n          = 1'b1;
        bus.pll_locked = 1'b0;
        for (int p = 1; p <= pulses; p++) begin
            exp_iq.push_back(4);
            count_while(1'b1, 20, n);
            check_int($sformatf("timeout_pulse%0d_high", p), n, exp_iq.pop_front());
            exp_iq.push_back(low_exp);
            count_while(1'b0, 150, n);
            check_int($sformatf("timeout_pulse%0d_low", p), n, exp_iq.pop_front());
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
            rtc_exp = (p > 3) ? 3 : p;
`else
            rtc_exp = 0;
`endif
            exp_iq.push_back(rtc_exp);
            check_int($sformatf("timeout_retry%0d", p), int'(bus.retry_cnt), exp_iq.pop_front());
            check_int($sformatf("timeout_ready%0d", p), int'(bus.ready), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock supervisor and reset sequencer placed directly downstream of the system PLL. Runs on the 50 MHz PLL reference clock and drives the PLL's active-high reset. It synchronizes and qualifies the PLL `locked` output, then releases staggered active-low reset requests to the consumers of the PLL output clocks. On loss of lock it re-asserts all downstream resets and restarts the PLL.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK+STABLE before a PLL retry (≥1).
- `NUM_RESETS`, 3: number of downstream reset outputs, one per PLL output clock (≥1).
- `STAGGER_CYCLES`, 8: spacing between successive reset releases (≥1).
- `CNT_W`, 8: width of the status counters.

Ports:
- `refclk`, in, 1: reference clock, 50 MHz; the only clock.
- `rst_n`, in, 1: **synchronous, active-low** reset.
- `pll_locked`, in, 1: PLL `locked`, asynchronous to `refclk`.
- `pll_rst`, out, 1: PLL reset, active high.
- `rst_out_n`, out, NUM_RESETS: downstream reset requests, active low. Each receiver synchronizes its bit into its own clock domain.
- `ready`, out, 1: all downstream resets released.
- `state`, out, 3: current FSM state code.
- `lock_loss_cnt`, out, CNT_W: saturating count of lock losses while in RELEASE or RUN.
- `retry_cnt`, out, CNT_W: saturating count of timeout retries.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s` only.
- FSM state codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- **RESET_PLL:** `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then the FSM moves to WAIT_LOCK. The timeout counter clears on exit.
- **WAIT_LOCK:** `pll_rst`=0. When `locked_s`=1, go to STABLE and clear the stability counter.
- **STABLE:** the stability counter increments each cycle `locked_s`=1.
  - If `locked_s`=0, return to WAIT_LOCK. No PLL reset, no counter change.
  - After LOCK_STABLE_CYCLES consecutive high cycles, go to RELEASE.
- **Timeout:** the timeout counter runs through WAIT_LOCK and STABLE. On reaching LOCK_TIMEOUT_CYCLES, go to RESET_PLL and increment `retry_cnt` (saturating).
- **RELEASE:** `rst_out_n[0]` goes high in the first RELEASE cycle. `rst_out_n[i]` goes high STAGGER_CYCLES cycles after `rst_out_n[i-1]`. In the cycle the last bit goes high, the FSM enters RUN and `ready` goes to 1 in the same cycle.
- **RUN:** hold all outputs until lock is lost.
- **Lock loss:** `locked_s`=0 while in RELEASE or RUN triggers all of the following on the next clock edge:
  - all `rst_out_n`=0, `ready`=0;
  - `lock_loss_cnt`+1 (saturating);
  - FSM goes to RESET_PLL.
- Released `rst_out_n` bits never re-assert individually; all bits re-assert together.
- Counters saturate at 2^CNT_W−1 and never wrap. They clear only on `rst_n`.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `pll_rst`=1, `rst_out_n`=all 0, `ready`=0;
  - `state`=RESET_PLL, `lock_loss_cnt`=0, `retry_cnt`=0;
  - synchronizer and all internal counters 0.
- The first cycle after reset release is RESET_PLL cycle 1.
- `rst_n` asserted mid-operation overrides every state and applies the reset values at the next edge.
- All outputs are registered. There is no combinational path from any input to any output.
- Latencies:
  - `pll_locked` rise to `locked_s`: 2 cycles. One more cycle to enter STABLE.
  - `pll_locked` fall to `rst_out_n`=0: 3 edges (2 synchronizer + 1 output register).
- Simultaneous events:
  - Timeout expiry and the final stability count in the same cycle: stability wins, go to RELEASE.
  - Timeout expiry and `locked_s` drop in STABLE: timeout wins.

## Configuration
- `PLL_RESET_SEQ_TIMEOUT_EN`:
  - Defined: timeout/retry behaviour as specified above.
  - Undefined: no timeout counter. WAIT_LOCK and STABLE wait indefinitely, and `retry_cnt` is tied to 0.

## Test plan
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=100, NUM_RESETS=3, STAGGER_CYCLES=2.
- **Clean bring-up:** release `rst_n` with `pll_locked`=1. Expect `pll_rst` high for cycles 1–4 and STABLE entered 1 cycle after WAIT_LOCK is entered (`locked_s` already high). After 8 cycles, `rst_out_n` goes 001→011→111 at 2-cycle spacing, with `ready`=1 together with 111.
- **Glitch during STABLE:** drop `pll_locked` for 1 cycle after 5 stable cycles. Expect return to WAIT_LOCK, `pll_rst` stays 0, no counter change, and a full 8-cycle requalification.
- **Lock loss in RUN:** drop `pll_locked`. Expect `rst_out_n`=000 and `ready`=0 on the 3rd edge, `lock_loss_cnt`=1, and a 4-cycle `pll_rst` pulse, then normal re-sequencing.
- **Timeout:** hold `pll_locked`=0. Expect `pll_rst` pulses every 104 cycles and `retry_cnt` 1, 2, 3…; with the macro undefined, a single pulse and `retry_cnt`=0.
- **Saturation/reset:** with CNT_W=2, cause 5 lock losses and expect `lock_loss_cnt`=3. Assert `rst_n` during RELEASE and expect all reset values on the next edge.
